// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit blocks:
//   UART_DATA_BITS  payload bits per frame (8N1 framing)
//   rx_state_e      receiver FSM states
//   majority3()     2-of-3 vote used for oversampled bit recovery
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered_if
// Consumer-side port bundle of the buffered UART receiver.
//   data           FIFO head byte, valid only while data_valid
//   data_valid     FIFO not empty
//   data_ready     consumer pops the head on data_valid & data_ready
//   framing_error  1-cycle pulse, stop bit sampled low
//   overrun        1-cycle pulse, good byte dropped because FIFO full
//   fifo_count     current FIFO occupancy
// master: the receiver. slave: the consumer.
// ---------------------------------------------------------------------------
interface uart_rx_buffered_if #(
  parameter int FIFO_DEPTH = 16
);

  logic [uart_pkg::UART_DATA_BITS-1:0] data;
  logic                                data_valid;
  logic                                data_ready;
  logic                                framing_error;
  logic                                overrun;
  logic [$clog2(FIFO_DEPTH):0]         fifo_count;

  modport master (
    output data, data_valid, framing_error, overrun, fifo_count,
    input  data_ready
  );

  modport slave (
    input  data, data_valid, framing_error, overrun, fifo_count,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO for received bytes.
//   clk, reset_n   clock, synchronous active-low reset
//   push/push_data write request; ignored when full unless a pop happens
//                  in the same cycle
//   pop            remove head; ignored when empty
//   head           current head entry, forced to 0 while empty
//   full, empty    occupancy flags
//   count          occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: reset is sampled inside the clocked block, so it is synchronous.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly AW bits wide, so they wrap modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: storage has no reset; empty/count gate every read, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// uart_rx_buffered
// 8N1 UART receiver with 3-sample majority voting and a receive FIFO.
//   clk      core clock
//   reset_n  synchronous active-low reset; aborts any frame in progress
//   rx       serial input, already synchronised to clk, idle high
//   rx_if    consumer port (master side): FWFT data/data_valid/data_ready,
//            framing_error and overrun pulses, fifo_count
// The sample-tick divider, receive FSM and shifter live here; buffering
// is delegated to uart_rx_fifo.
// ---------------------------------------------------------------------------
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  uart_rx_buffered_if.master rx_if
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int IW  = $clog2(UART_DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_VOTE_A = SW'(M - 1);
  localparam logic [SW-1:0] S_VOTE_B = SW'(M);
  localparam logic [SW-1:0] S_DECIDE = SW'(M + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx_buffered: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 2");
    end
    if (OVERSAMPLE < 8) begin : g_os_check
      $error("uart_rx_buffered: OVERSAMPLE must be >= 8");
    end
  endgenerate

  // ---------------- sample-tick divider ----------------
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // ---------------- receive FSM and shifter ----------------
  rx_state_e                 state;
  logic [SW-1:0]             s_cnt;
  logic [IW-1:0]             bit_idx;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      samp_a;
  logic                      samp_b;
  logic                      start_vote;
  logic                      vote;
  logic                      push;
  logic                      framing_error_q;
  logic                      overrun_q;
  logic                      fifo_full;
  logic                      fifo_empty;

  // Only meaningful on the tick where s_cnt == S_DECIDE: the two earlier
  // samples are registered, the third is the live line.
  assign vote = majority3(samp_a, samp_b, rx);

  // Stop decision with a high stop bit hands the byte to the FIFO; it is
  // visible at data/data_valid on the following cycle.
  assign push = tick && (state == RX_STOP) && (s_cnt == S_DECIDE) && vote;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= RX_IDLE;
      s_cnt           <= '0;
      bit_idx         <= '0;
      shift_q         <= '0;
      samp_a          <= 1'b0;
      samp_b          <= 1'b0;
      start_vote      <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      framing_error_q <= 1'b0;
      if (tick) begin
        if (s_cnt == S_VOTE_A) samp_a <= rx;
        if (s_cnt == S_VOTE_B) samp_b <= rx;

        case (state)
          RX_IDLE: begin
            if (!rx) begin
              state <= RX_START;
              s_cnt <= '0;
            end
          end

          RX_START: begin
            if (s_cnt == S_DECIDE) start_vote <= vote;
            if (s_cnt == S_LAST) begin
              s_cnt   <= '0;
              bit_idx <= '0;
              // A start bit that votes high was a glitch: drop it silently.
              state   <= start_vote ? RX_IDLE : RX_DATA;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end

          RX_DATA: begin
            // LSB arrives first, so shifting in from the top leaves bit 0
            // in the LSB after the last data bit.
            if (s_cnt == S_DECIDE) shift_q <= {vote, shift_q[UART_DATA_BITS-1:1]};
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              if (bit_idx == IDX_LAST) state   <= RX_STOP;
              else                     bit_idx <= bit_idx + IW'(1);
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end

          RX_STOP: begin
            // Decide mid-bit so a back-to-back start edge is never missed.
            if (s_cnt == S_DECIDE) begin
              s_cnt           <= '0;
              state           <= vote ? RX_IDLE : RX_BREAK;
              framing_error_q <= ~vote;
            end else begin
              s_cnt <= s_cnt + SW'(1);
            end
          end

          RX_BREAK: begin
            // Hold here while the line stays low so a break reports once.
            if (rx) state <= RX_IDLE;
          end

          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  // A push into a full FIFO is lost unless the consumer pops the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) overrun_q <= 1'b0;
    else          overrun_q <= push & fifo_full & ~rx_if.data_ready;
  end

  // ---------------- receive FIFO ----------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (rx_if.data_ready),
    .head      (rx_if.data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_if.fifo_count)
  );

  assign rx_if.data_valid    = ~fifo_empty;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_buffered
// Self-checking bench for uart_rx_buffered. Frames are generated bit by bit
// from the 8N1 line format; expected bytes, error pulses and FIFO occupancy
// come from a queue-based model of a bounded FIFO.
// ---------------------------------------------------------------------------
module tb_uart_rx_buffered;

  localparam int CLK_HZ     = 3_200_000;
  localparam int BAUD       = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int DEPTH      = 4;
  localparam int BIT_CLK    = CLK_HZ / BAUD;   // 32 clk per bit
  localparam int LFSR_BYTES = 160;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;

  uart_rx_buffered_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

  uart_rx_buffered #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fe_pulses = 0;
  int          ovr_pulses = 0;
  int          dv_rise_cyc = -1;
  logic        dv_prev = 1'b0;
  logic [7:0]  got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_if.framing_error) fe_pulses++;
      if (rx_if.overrun) ovr_pulses++;
      if (rx_if.data_valid && rx_if.data_ready) got_q.push_back(rx_if.data);
      if (rx_if.data_valid && !dv_prev) dv_rise_cyc = cyc;
    end
    dv_prev = rx_if.data_valid;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drive one 8N1 frame. glitch_bit >= 0 flips that data bit for two clocks
  // (one sample tick) around the middle of the bit.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                             input int glitch_bit, output int start_cyc);
    logic [9:0] frame;
    logic       flip;
    frame     = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < BIT_CLK; k++) begin
        flip = (glitch_bit >= 0) && (i == glitch_bit + 1) && (k == 15 || k == 16);
        rx = frame[i] ^ flip;
        step();
      end
    end
  endtask

  task automatic drain();
    rx_if.data_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && rx_if.data_valid; i++) step();
    rx_if.data_ready = 1'b0;
    step();
    n_checks++;
    if (rx_if.data_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_timeout: data_valid=%b required 0", rx_if.data_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx = 1'b1; rx_if.data_ready = 1'b0;
    step(3);
    n_checks += 5;
    if (rx_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h required 00", rx_if.data); end
    if (rx_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", rx_if.data_valid); end
    if (rx_if.framing_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b required 0", rx_if.framing_error); end
    if (rx_if.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b required 0", rx_if.overrun); end
    if (rx_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", rx_if.fifo_count); end
    reset_n = 1'b1;
    step(4);
    n_checks++;
    if (rx_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b required 0", rx_if.data_valid); end
  endtask

  task automatic test_frame();
    int st;
    int lat;
    got_q.delete();
    dv_rise_cyc = -1;
    drive_frame(8'hA5, 1'b1, -1, st);
    lat = dv_rise_cyc - st;
    n_checks += 4;
    if (rx_if.data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h required a5", rx_if.data); end
    if (rx_if.fifo_count !== 3'd1) begin n_fail++; $display("FAIL a5_count: got %0d required 1", rx_if.fifo_count); end
    // Byte must appear during the stop bit: after 9 bits, before 10.
    if (dv_rise_cyc < 0 || lat <= 9 * BIT_CLK || lat > 10 * BIT_CLK) begin
      n_fail++; $display("FAIL a5_latency: got %0d clk required (%0d,%0d]", lat, 9 * BIT_CLK, 10 * BIT_CLK);
    end
    if (fe_pulses !== 0) begin n_fail++; $display("FAIL a5_fe: got %0d pulses required 0", fe_pulses); end
    drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL a5_pop: got %0d bytes first %h required 1 byte a5", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_glitch();
    int st;
    int fe0;
    fe0 = fe_pulses;
    got_q.delete();
    rx = 1'b0; step(8);
    rx = 1'b1; step(3 * BIT_CLK);
    n_checks += 2;
    if (rx_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b required 0", rx_if.data_valid); end
    if (fe_pulses != fe0) begin n_fail++; $display("FAIL glitch_fe: got %0d pulses required 0", fe_pulses - fe0); end
    drive_frame(8'h3C, 1'b1, -1, st);
    n_checks++;
    if (rx_if.data !== 8'h3C) begin n_fail++; $display("FAIL glitch_next: got %h required 3c", rx_if.data); end
    drain();
  endtask

  task automatic test_framing();
    int st;
    int fe0;
    fe0 = fe_pulses;
    drive_frame(8'h3C, 1'b0, -1, st);
    rx = 1'b1; step(BIT_CLK);
    n_checks += 2;
    if (fe_pulses - fe0 != 1) begin n_fail++; $display("FAIL fe_pulses: got %0d required 1", fe_pulses - fe0); end
    if (rx_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL fe_count: got %0d required 0", rx_if.fifo_count); end
    drive_frame(8'h55, 1'b1, -1, st);
    n_checks += 2;
    if (rx_if.data !== 8'h55) begin n_fail++; $display("FAIL fe_next: got %h required 55", rx_if.data); end
    if (fe_pulses - fe0 != 1) begin n_fail++; $display("FAIL fe_after: got %0d required 1", fe_pulses - fe0); end
    drain();
  endtask

  task automatic test_overrun();
    int st;
    int ovr0;
    int exp_ovr;
    logic [7:0] mq[$];
    ovr0 = ovr_pulses;
    exp_ovr = 0;
    got_q.delete();
    rx_if.data_ready = 1'b0;
    for (int v = 0; v < 5; v++) begin
      drive_frame(8'(v), 1'b1, -1, st);
      if (mq.size() < DEPTH) mq.push_back(8'(v));
      else exp_ovr++;
    end
    n_checks += 3;
    if (rx_if.fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL ovr_count: got %0d required %0d", rx_if.fifo_count, mq.size()); end
    if (ovr_pulses - ovr0 != exp_ovr) begin n_fail++; $display("FAIL ovr_pulses: got %0d required %0d", ovr_pulses - ovr0, exp_ovr); end
    if (rx_if.data !== mq[0]) begin n_fail++; $display("FAIL ovr_head: got %h required %h", rx_if.data, mq[0]); end
    drain();
    n_checks++;
    if (got_q.size() != mq.size()) begin n_fail++; $display("FAIL ovr_popcount: got %0d required %0d", got_q.size(), mq.size()); end
    for (int i = 0; i < mq.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== mq[i]) begin n_fail++; $display("FAIL ovr_order[%0d]: got %h required %h", i, got_q[i], mq[i]); end
    end
  endtask

  task automatic test_noise();
    int st;
    int fe0;
    fe0 = fe_pulses;
    drive_frame(8'hF0, 1'b1, 3, st);
    n_checks += 2;
    if (rx_if.data !== 8'hF0) begin n_fail++; $display("FAIL noise_data: got %h required f0", rx_if.data); end
    if (fe_pulses != fe0) begin n_fail++; $display("FAIL noise_fe: got %0d required 0", fe_pulses - fe0); end
    drain();
  endtask

  task automatic test_reset_mid();
    int st;
    logic [9:0] fr;
    rx_if.data_ready = 1'b0;
    drive_frame(8'h42, 1'b1, -1, st);
    fr = {1'b1, 8'h99, 1'b0};
    // Stop partway through data bit 4 (frame position 5).
    for (int i = 0; i < 5 * BIT_CLK + 10; i++) begin
      rx = fr[i / BIT_CLK];
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    n_checks += 5;
    if (rx_if.data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h required 00", rx_if.data); end
    if (rx_if.data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", rx_if.data_valid); end
    if (rx_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d required 0", rx_if.fifo_count); end
    if (rx_if.framing_error !== 1'b0) begin n_fail++; $display("FAIL midrst_fe: got %b required 0", rx_if.framing_error); end
    if (rx_if.overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %b required 0", rx_if.overrun); end
    rx = 1'b1; step(2 * BIT_CLK);
    got_q.delete();
    drive_frame(8'h81, 1'b1, -1, st);
    drain();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      n_fail++; $display("FAIL midrst_next: got %0d bytes first %h required 1 byte 81", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_random();
    int st;
    int fe0;
    int ovr0;
    int exp_fe;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic bad;
    fe0 = fe_pulses; ovr0 = ovr_pulses; exp_fe = 0;
    got_q.delete();
    rx_if.data_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      drive_frame(b, ~bad, -1, st);
      if (bad) exp_fe++;
      else     exp_q.push_back(b);
      rx = 1'b1;
      // After a bad stop bit the line must be seen high before the next start.
      step(bad ? $urandom_range(4, 40) : $urandom_range(0, 40));
    end
    step(4);
    rx_if.data_ready = 1'b0;
    n_checks += 3;
    if (fe_pulses - fe0 != exp_fe) begin n_fail++; $display("FAIL rnd_fe: got %0d required %0d", fe_pulses - fe0, exp_fe); end
    if (ovr_pulses != ovr0) begin n_fail++; $display("FAIL rnd_ovr: got %0d required 0", ovr_pulses - ovr0); end
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_len: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    int fe0;
    int ovr0;
    int bad_cnt;
    logic [7:0] v;
    logic [7:0] exp_q[$];
    fe0 = fe_pulses; ovr0 = ovr_pulses; bad_cnt = 0;
    got_q.delete();
    rx_if.data_ready = 1'b1;
    v = 8'h01;
    for (int n = 0; n < LFSR_BYTES; n++) begin
      drive_frame(v, 1'b1, -1, st);
      exp_q.push_back(v);
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    rx = 1'b1;
    step(4);
    rx_if.data_ready = 1'b0;
    n_checks += 3;
    if (fe_pulses != fe0) begin n_fail++; $display("FAIL b2b_fe: got %0d required 0", fe_pulses - fe0); end
    if (ovr_pulses != ovr0) begin n_fail++; $display("FAIL b2b_ovr: got %0d required 0", ovr_pulses - ovr0); end
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) bad_cnt++;
    end
    n_checks++;
    if (bad_cnt != 0) begin n_fail++; $display("FAIL b2b_order: got %0d wrong bytes required 0", bad_cnt); end
  endtask

  initial begin
    rx_if.data_ready = 1'b0;
    test_reset();
    test_frame();
    test_glitch();
    test_framing();
    test_overrun();
    test_noise();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
